// File: rtl/print_uart_tx.sv
// print_uart_tx: console output stage, buffers print-store characters
// in a small FIFO and serialises them onto a UART 8N1 line.
module print_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          start,
  input  logic                          print_en,
  input  logic [31:0]                   print_data,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            unused_hi;

  assign unused_hi = ^print_data[31:8];

  // Next-state: FIFO bookkeeping, frame sequencing and line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    push    = print_en && (cnt_q < CW'(FIFO_DEPTH));
    bit_end = (baud_q == BW'(CPB - 1));

    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (print_en && !push) ovf_d = 1'b1;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    unique case (1'b1)
      (state_d == S_START): tx_d = 1'b0;
      (state_d == S_DATA):  tx_d = shift_d[0];
      default:              tx_d = 1'b1;
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end

  // Character storage; contents are don't-care once pointers clear
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= print_data[7:0];
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = (cnt_q != '0) || (state_q != S_IDLE);
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// tb_print_uart_tx: randomized bench for print_uart_tx against a
// queue-and-frame-timer reference model plus a line decoder.
module tb_print_uart_tx;

  localparam int C = 10;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        start;
  logic        print_en;
  logic [31:0] print_data;
  logic        uart_tx;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  print_uart_tx #(
    .CLK_FREQ(50_000_000),
    .BAUD(5_000_000),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .start(start),
    .print_en(print_en),
    .print_data(print_data),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  bq_t        mq;
  bq_t        sent;
  logic [7:0] cur;
  int         m_timer;
  logic       m_ovf;
  logic       hist[$];
  int         starts[$];
  int         n_run;
  int         n_fail;

  function automatic logic m_tx();
    int j;
    int b;
    if (m_timer == 0) return 1'b1;
    j = 10 * C - m_timer;
    b = j / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  function automatic bq_t decode();
    bq_t        r;
    int         i;
    logic [7:0] b;
    starts.delete();
    i = 1;
    while (i < hist.size()) begin
      if (hist[i-1] == 1'b1 && hist[i] == 1'b0 &&
          i + 95 < hist.size()) begin
        for (int k = 0; k < 8; k++) b[k] = hist[i + 15 + 10 * k];
        r.push_back(b);
        starts.push_back(i);
        i += 100;
      end else begin
        i++;
      end
    end
    return r;
  endfunction

  task automatic tick(input logic en, input logic [31:0] d);
    int pre;
    print_en   = en;
    print_data = d;
    @(posedge clk);
    pre = mq.size();
    if (m_timer == 0 && pre != 0) begin
      cur = mq.pop_front();
      sent.push_back(cur);
      m_timer = 10 * C;
    end else if (m_timer > 0) begin
      m_timer--;
    end
    if (en) begin
      if (pre < D) mq.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    #1;
    print_en = 1'b0;
    hist.push_back(uart_tx);
  endtask

  task automatic do_reset();
    start = 1'b0;
    print_en = 1'b0;
    #1;
    mq.delete();
    sent.delete();
    hist.delete();
    m_timer = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0;
    print_en = 1'b0;
    print_data = '0;
    #3;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 ||
        fifo_count !== 3'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: got tx=%b busy=%b cnt=%0d ovf=%b, want 1 0 0 0",
               uart_tx, tx_busy, fifo_count, overflow);
    end
    start = 1'b1;
    tick(1'b1, 32'h0000_0031);
    tick(1'b1, 32'h0000_0032);
    repeat (3) tick(1'b0, 32'h0);
    n_run++;
    if (uart_tx !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_pre: got tx=%b cnt=%0d, want 0 1",
               uart_tx, fifo_count);
    end
    #2;
    start = 1'b0;
    #1;
    n_run++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 ||
        fifo_count !== 3'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got tx=%b busy=%b cnt=%0d ovf=%b, want 1 0 0 0",
               uart_tx, tx_busy, fifo_count, overflow);
    end
  endtask

  task automatic test_single();
    bq_t  rx;
    logic exp_bits [10];
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    tick(1'b1, 32'hDEAD_BE41);
    n_run++;
    if (fifo_count !== 3'd1 || tx_busy !== 1'b1 || uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push: got cnt=%0d busy=%b tx=%b, want 1 1 1",
               fifo_count, tx_busy, uart_tx);
    end
    tick(1'b0, 32'h0);
    n_run++;
    if (fifo_count !== 3'd0 || uart_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: got cnt=%0d tx=%b, want 0 0",
               fifo_count, uart_tx);
    end
    repeat (99) tick(1'b0, 32'h0);
    n_run++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_stop: got %b want 1", tx_busy);
    end
    tick(1'b0, 32'h0);
    n_run++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b tx=%b, want 0 1",
               tx_busy, uart_tx);
    end
    for (int k = 0; k < 10; k++) begin
      n_run++;
      if (hist[1 + 5 + 10 * k] !== exp_bits[k]) begin
        n_fail++;
        $display("FAIL single_bit%0d: got %b want %b",
                 k, hist[1 + 5 + 10 * k], exp_bits[k]);
      end
    end
    rx = decode();
    n_run++;
    if (rx.size() != 1 || rx[0] !== 8'h41) begin
      n_fail++;
      $display("FAIL single_decode: got n=%0d b0=%h, want 1 41",
               rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    bq_t        rx;
    logic [2:0] pk;
    do_reset();
    pk = '0;
    tick(1'b1, 32'h0000_0048);
    if (fifo_count > pk) pk = fifo_count;
    tick(1'b1, 32'h0000_0069);
    for (int i = 0; i < 220; i++) begin
      if (fifo_count > pk) pk = fifo_count;
      tick(1'b0, 32'h0);
    end
    n_run++;
    if (pk !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_peak: got %0d want 1", pk);
    end
    rx = decode();
    n_run++;
    if (rx.size() != 2 || rx[0] !== 8'h48 || rx[1] !== 8'h69) begin
      n_fail++;
      $display("FAIL b2b_decode: got n=%0d, want 2 bytes 48 69", rx.size());
    end
    n_run++;
    if (starts.size() != 2 || starts[1] - starts[0] != 101) begin
      n_fail++;
      $display("FAIL b2b_period: got n=%0d gap=%0d, want 2 101",
               starts.size(),
               (starts.size() == 2) ? starts[1] - starts[0] : -1);
    end
  endtask

  task automatic test_overflow();
    bq_t        rx;
    logic [7:0] ch [7];
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ch[i] = 8'($urandom());
      tick(1'b1, {24'($urandom()), ch[i]});
      if (i == 4) begin
        n_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_fill: got cnt=%0d ovf=%b, want 4 0",
                   fifo_count, overflow);
        end
      end
      if (i == 5) begin
        n_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_6th: got cnt=%0d ovf=%b, want 4 1",
                   fifo_count, overflow);
        end
      end
    end
    for (int i = 0; i < 530; i++) begin
      tick(1'b0, 32'h0);
      n_run++;
      if (uart_tx !== m_tx() || fifo_count !== 3'(mq.size()) ||
          overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL ovf_cyc%0d: got tx=%b cnt=%0d ovf=%b, want %b %0d %b",
                 i, uart_tx, fifo_count, overflow,
                 m_tx(), mq.size(), m_ovf);
      end
    end
    rx = decode();
    n_run++;
    if (rx.size() != 5) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d bytes want 5", rx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_run++;
        if (rx[i] !== ch[i]) begin
          n_fail++;
          $display("FAIL ovf_byte%0d: got %h want %h", i, rx[i], ch[i]);
        end
      end
    end
    n_run++;
    if (overflow !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b busy=%b, want 1 0",
               overflow, tx_busy);
    end
  endtask

  task automatic test_push_pop();
    bq_t        rx;
    logic [7:0] ch [5];
    int         g;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, $urandom());
    g = 0;
    while (!(m_timer == 0 && mq.size() != 0) && g < 400) begin
      tick(1'b0, 32'h0);
      g++;
    end
    n_run++;
    if (g >= 400 || fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_full_wait: got g=%0d cnt=%0d ovf=%b, want <400 4 0",
               g, fifo_count, overflow);
    end
    tick(1'b1, $urandom());
    n_run++;
    if (overflow !== 1'b1 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL pp_full_drop: got ovf=%b cnt=%0d, want 1 3",
               overflow, fifo_count);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ch[i] = 8'($urandom());
      tick(1'b1, {24'hABCDEF, ch[i]});
    end
    g = 0;
    while (!(m_timer == 0 && mq.size() != 0) && g < 400) begin
      tick(1'b0, 32'h0);
      g++;
    end
    n_run++;
    if (g >= 400 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL pp_three_wait: got g=%0d cnt=%0d, want <400 3",
               g, fifo_count);
    end
    ch[4] = 8'($urandom());
    tick(1'b1, {24'h123456, ch[4]});
    n_run++;
    if (fifo_count !== 3'd3 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_both: got cnt=%0d ovf=%b, want 3 0",
               fifo_count, overflow);
    end
    repeat (420) tick(1'b0, 32'h0);
    rx = decode();
    n_run++;
    if (rx.size() != 5) begin
      n_fail++;
      $display("FAIL pp_count: got %0d bytes want 5", rx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_run++;
        if (rx[i] !== ch[i]) begin
          n_fail++;
          $display("FAIL pp_byte%0d: got %h want %h", i, rx[i], ch[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    int         bad;
    do_reset();
    a = 8'($urandom());
    tick(1'b1, {24'h0, a});
    tick(1'b1, $urandom());
    tick(1'b1, $urandom());
    repeat (54) tick(1'b0, 32'h0);
    n_run++;
    if (uart_tx !== a[4] || fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_bit4: got tx=%b cnt=%0d, want %b 2",
               uart_tx, fifo_count, a[4]);
    end
    #2;
    start = 1'b0;
    #1;
    n_run++;
    if (uart_tx !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got tx=%b cnt=%0d busy=%b, want 1 0 0",
               uart_tx, fifo_count, tx_busy);
    end
    do_reset();
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1'b0, 32'h0);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    bq_t  rx;
    logic en;
    int   nbad;
    do_reset();
    for (int i = 0; i < 1300; i++) begin
      en = (i < 800) && ($urandom_range(0, 9) == 0);
      tick(en, $urandom());
      n_run++;
      if (uart_tx !== m_tx() || fifo_count !== 3'(mq.size()) ||
          overflow !== m_ovf ||
          tx_busy !== (mq.size() != 0 || m_timer != 0)) begin
        n_fail++;
        $display("FAIL rnd_cyc%0d: got tx=%b cnt=%0d ovf=%b busy=%b, want %b %0d %b",
                 i, uart_tx, fifo_count, overflow, tx_busy,
                 m_tx(), mq.size(), m_ovf);
      end
    end
    rx = decode();
    nbad = 0;
    if (rx.size() == sent.size()) begin
      foreach (rx[i]) if (rx[i] !== sent[i]) nbad++;
    end
    n_run++;
    if (rx.size() != sent.size() || nbad != 0) begin
      n_fail++;
      $display("FAIL rnd_decode: got n=%0d bad=%0d, want n=%0d bad=0",
               rx.size(), nbad, sent.size());
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    m_timer = 0;
    m_ovf = 1'b0;
    cur = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
# print_uart_tx

Console output stage downstream of the load/store unit. It captures the single-cycle `print_en`/`print_data` strobe raised by data memory on a store to the print address and buffers the character in a small FIFO. It serialises each character onto a UART 8N1 line. This decouples program stores, which run at one per cycle, from the much slower serial link.

## Interface

**Parameters**

- `CLK_FREQ`, default 50_000_000: core clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division, truncated. Must be ≥ 2.
- `FIFO_DEPTH`, default 16: character FIFO entries. Power of two, ≥ 2.

**Ports**

- `clk`, input, 1: core clock. All state updates on the rising edge.
- `start`, input, 1: reset, asynchronous, active-low. Low clears all state immediately. High means run.
- `print_en`, input, 1: one-cycle write strobe from data memory.
- `print_data`, input, 32: store data. Only bits [7:0] are transmitted; bits [31:8] are ignored.
- `uart_tx`, output, 1: serial line, registered. Idle level is 1.
- `tx_busy`, output, 1: 1 when the FIFO is non-empty or the FSM is not in IDLE.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow`, output, 1: sticky flag, set when a strobe is dropped because the FIFO is full.

## Operation

**Reset values** (while `start` = 0):
- `uart_tx` = 1, `tx_busy` = 0, `fifo_count` = 0, `overflow` = 0.
- FSM = IDLE; read and write pointers = 0; bit counter and baud counter = 0.

**FIFO**
- Circular buffer with pointers that wrap modulo `FIFO_DEPTH`.
- Push when `print_en` = 1 and `fifo_count` < `FIFO_DEPTH` at that edge: store `print_data[7:0]` and increment the write pointer.
- Push while full (judged on the pre-edge count, even if a pop happens in the same cycle): data is dropped and `overflow` is set to 1. `overflow` stays set until reset.
- Pop is performed only by the FSM (IDLE→START).
- Simultaneous push and pop with the FIFO not full: both happen and `fifo_count` is unchanged.

**FSM**

States: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1 within each bit.

- **IDLE:** `uart_tx` = 1. If `fifo_count` ≠ 0, pop the head into the shift register, clear the baud counter, and go to START.
- **START:** `uart_tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:** `uart_tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right and the index increments. After bit 7 completes, go to STOP.
- **STOP:** `uart_tx` = 1 for CLKS_PER_BIT cycles, then go to IDLE.

**Reset mid-frame:** the line returns to 1 asynchronously, the frame is abandoned, and FIFO contents are discarded.

## Timing

- A `print_en` sampled at edge N into an empty FIFO gives `fifo_count` = 1 after N.
- At edge N+1 the FSM pops: `fifo_count` = 0 and `uart_tx` falls after N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back characters: STOP → IDLE, then the pop on the next edge. This gives exactly 1 extra idle-high cycle between frames, so the frame period is 10·CLKS_PER_BIT+1 cycles.
- `tx_busy` is combinational from registered state. It goes high after edge N and low in the first IDLE cycle with an empty FIFO.
- Sustained `print_en` at one per cycle fills the FIFO in FIFO_DEPTH cycles. With one pop overlapping during fill, `overflow` sets on the (FIFO_DEPTH+2)-th strobe.

## Test plan

Parameters for all scenarios: `CLK_FREQ` = 50_000_000, `BAUD` = 5_000_000 (CLKS_PER_BIT = 10), `FIFO_DEPTH` = 4.

1. **Reset values.** Hold `start` low, pulse `clk` → `uart_tx` = 1, `tx_busy` = 0, `fifo_count` = 0, `overflow` = 0. Drop `start` asynchronously mid-cycle → outputs clear without waiting for a clock edge.
2. **Single character.** `print_en` with `print_data` = 0xDEAD_BE41 at edge N → `uart_tx` falls after N+1. Sampled line at mid-bit is 0, 1,0,0,0,0,0,1,0 (0x41, LSB first), 1. Returns to IDLE after 100 cycles and `tx_busy` drops.
3. **Back-to-back.** Strobe "H","i" on consecutive cycles → `fifo_count` peaks at 1. Second start bit falls 101 cycles after the first. Decoded bytes are 0x48, 0x69.
4. **Overflow.** Strobe 7 characters on 7 consecutive cycles → first 5 accepted (one popped during fill), `fifo_count` = 4, `overflow` = 1 after the 6th strobe. Decoded output is the first 5 characters only. `overflow` stays 1 after draining.
5. **Simultaneous push/pop.** Full FIFO and FSM popping on the same edge as `print_en` → strobe is dropped, `overflow` = 1. With 3 entries and a push plus pop on the same edge → `fifo_count` stays 3 and ordering is preserved.
6. **Reset mid-frame.** Assert `start` low during DATA bit 4 → `uart_tx` = 1 at once. After release, with no new strobes, no further frame is sent.
